// File: rtl/tap_tempo.sv
// rtl/tap_tempo.sv - tap interval to prescaler divisor; TAP_AVERAGE_EN averages the last two periods
`timescale 1ns/1ps
module tap_tempo #(
    parameter int WIDTH             = 27,
    parameter int MIN_PERIOD        = 2_500_000,
    parameter int MAX_PERIOD        = 100_000_000,
    parameter int DEFAULT_PRESCALER = 24_999_999
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic             iTAP,
    output logic [WIDTH-1:0] oPRESCALER,
    output logic             oVALID,
    output logic             oTIMEOUT
);

    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] MAX_P = WIDTH'(MAX_PERIOD);
    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PRESCALER);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t           state;
    logic             sync1, sync2, sync3;
    logic             tap;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] next_presc;

`ifdef TAP_AVERAGE_EN
    logic [WIDTH-1:0] prev;
    logic             prev_valid;
    logic [WIDTH:0]   avg_sum;

    assign avg_sum = {1'b0, count} + {1'b0, prev};
`endif

    assign tap = sync2 & ~sync3;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= iTAP;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_comb begin
        next_presc = (count >> 1) - WIDTH'(1);
`ifdef TAP_AVERAGE_EN
        if (prev_valid)
            next_presc = WIDTH'(avg_sum >> 2) - WIDTH'(1);
`endif
    end

    // count holds the cycles elapsed since the last accepted tap, so in the
    // cycle of the next tap it equals that tap's period P.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state      <= IDLE;
            count      <= '0;
            oPRESCALER <= DEF_P;
            oVALID     <= 1'b0;
            oTIMEOUT   <= 1'b0;
`ifdef TAP_AVERAGE_EN
            prev       <= '0;
            prev_valid <= 1'b0;
`endif
        end else begin
            oVALID   <= 1'b0;
            oTIMEOUT <= 1'b0;
            case (state)
                IDLE: begin
                    if (tap) begin
                        state <= MEASURE;
                        count <= WIDTH'(1);
                    end
                end
                MEASURE: begin
                    // count never exceeds MAX_P here, so only the lower bound is tested
                    if (tap && count >= MIN_P) begin
                        oPRESCALER <= next_presc;
                        oVALID     <= 1'b1;
                        count      <= WIDTH'(1);
`ifdef TAP_AVERAGE_EN
                        prev       <= count;
                        prev_valid <= 1'b1;
`endif
                    end else if (count == MAX_P) begin
                        oTIMEOUT <= 1'b1;
                        state    <= IDLE;
                        count    <= '0;
`ifdef TAP_AVERAGE_EN
                        prev_valid <= 1'b0;
`endif
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_tempo.sv
// tb/tb_tap_tempo.sv - scoreboard bench for tap_tempo
`timescale 1ns/1ps
module tb_tap_tempo;

    localparam int W     = 27;
    localparam int MIN_P = 10;
    localparam int MAX_P = 1000;
    localparam int DEF_P = 7;

    typedef struct {
        logic [W-1:0] value;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         tap_in;
    logic [W-1:0] presc;
    logic         valid;
    logic         timeout;

    exp_t         sb[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           n_valids = 0;
    int           n_timeouts = 0;
    int           exp_to = -1;
    int           last_r = 0;
    int           prev = 0;
    bit           active = 1'b0;
    bit           prev_valid = 1'b0;
    logic [W-1:0] cur_presc = W'(DEF_P);
    int           base_v;
    int           base_t;

    tap_tempo #(
        .WIDTH(W),
        .MIN_PERIOD(MIN_P),
        .MAX_PERIOD(MAX_P),
        .DEFAULT_PRESCALER(DEF_P)
    ) dut (
        .CLOCK_50(clk),
        .RESET(rst),
        .iTAP(tap_in),
        .oPRESCALER(presc),
        .oVALID(valid),
        .oTIMEOUT(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model_presc(input int p);
`ifdef TAP_AVERAGE_EN
        if (prev_valid) return W'(((p + prev) / 2) / 2) - W'(1);
`endif
        return W'(p / 2) - W'(1);
    endfunction

    // Model: a rise at negedge cycle r is a tap seen by the FSM at edge r+3.
    task automatic tap(input int d);
        int   r;
        int   p;
        exp_t e;
        r = cyc;
        tap_in = 1'b1;
        if (active && (r - last_r) <= MAX_P) begin
            p = r - last_r;
            if (p >= MIN_P) begin
                e.value = model_presc(p);
                e.cyc   = r + 3;
                sb.push_back(e);
                prev       = p;
                prev_valid = 1'b1;
                last_r     = r;
                exp_to     = r + 3 + MAX_P;
            end
        end else begin
            active     = 1'b1;
            prev_valid = 1'b0;
            last_r     = r;
            exp_to     = r + 3 + MAX_P;
        end
        repeat (2) @(negedge clk);
        tap_in = 1'b0;
        repeat (d - 2) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        active     = 1'b0;
        prev_valid = 1'b0;
        exp_to     = -1;
        sb.delete();
        cur_presc  = W'(DEF_P);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (valid) n_valids++;
        if (timeout) n_timeouts++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            check("valid_pulse", valid, 1);
            check("prescaler", presc, sb[0].value);
            cur_presc = sb[0].value;
            void'(sb.pop_front());
        end else if (valid) begin
            check("spurious_valid", valid, 0);
        end
        if (exp_to == cyc) begin
            check("timeout_pulse", timeout, 1);
            exp_to = -1;
        end else if (timeout) begin
            check("spurious_timeout", timeout, 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tap_in = 1'b0;
        @(negedge clk);
        do_reset(3);
        check("reset_prescaler", presc, DEF_P);
        check("reset_valid", valid, 0);
        check("reset_timeout", timeout, 0);
        repeat (50) @(negedge clk);
        check("idle_valids", n_valids, 0);
        check("idle_timeouts", n_timeouts, 0);

        base_v = n_valids;
        tap(100);
        tap(100);
        tap(20);
        check("steady_drained", sb.size(), 0);
        check("steady_count", n_valids - base_v, 2);
        check("steady_hold", presc, cur_presc);

        do_reset(2);
        base_v = n_valids;
        tap(5);
        tap(95);
        tap(20);
        check("bounce_drained", sb.size(), 0);
        check("bounce_count", n_valids - base_v, 1);
        check("bounce_value", presc, 49);

        do_reset(2);
        base_v = n_valids;
        base_t = n_timeouts;
        tap(101);
        tap(1100);
        check("timeout_count", n_timeouts - base_t, 1);
        check("timeout_hold", presc, 49);
        tap(60);
        tap(20);
        check("restart_drained", sb.size(), 0);
        check("restart_count", n_valids - base_v, 2);
        check("restart_value", presc, 29);

        do_reset(2);
        base_v = n_valids;
        tap(100);
        tap(50);
        check("pre_reset_value", presc, 49);
        do_reset(1);
        check("mid_reset_value", presc, DEF_P);
        repeat (49) @(negedge clk);
        tap(20);
        check("post_reset_count", n_valids - base_v, 1);
        check("post_reset_value", presc, DEF_P);

`ifdef TAP_AVERAGE_EN
        do_reset(2);
        base_v = n_valids;
        tap(100);
        tap(200);
        tap(1100);
        check("avg_value", presc, 74);
        tap(100);
        tap(20);
        check("avg_restart_value", presc, 49);
        check("avg_count", n_valids - base_v, 3);
`endif

        check("final_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
